// File: rtl/ram_req_ctrl_if.sv
// Request, response and RAM-port signals of the RAM request controller.
// The slave modport is the controller's view of the bus. The master modport is
// the view of whatever drives requests, consumes responses and models the RAM.
interface ram_req_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [ADDR_WIDTH-1:0] rsp_addr;

  logic                  wr_enb;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_enb;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, rd_data,
    output req_ready, rsp_valid, rsp_data, rsp_addr,
           wr_enb, wr_addr, wr_data, rd_enb, rd_addr
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready, rd_data,
    input  req_ready, rsp_valid, rsp_data, rsp_addr,
           wr_enb, wr_addr, wr_data, rd_enb, rd_addr
  );
endinterface

// File: rtl/ram_req_ctrl.sv
// Request-side front end for a RAM with separate write and read ports and a
// fixed 1-cycle read latency. Commands go out one per cycle, in order. Read
// data returns through a small response FIFO. Credits reserve a FIFO slot for
// every read still in flight, so rd_data never needs to be dropped.
module ram_req_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RSP_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst,
  ram_req_ctrl_if.slave  bus
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  // Wide enough to hold FIFO count plus the two in-flight read bits.
  localparam int CNT_W = $clog2(RSP_DEPTH + 3) + 1;

  // Issue stage: registered RAM-side outputs.
  logic                  r_wr_enb;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_rd_enb;
  logic [ADDR_WIDTH-1:0] r_rd_addr;

  // RAM stage: a read the RAM is servicing this cycle.
  logic                  r_rd_pend;
  logic [ADDR_WIDTH-1:0] r_pend_addr;

  // Response FIFO.
  logic [DATA_WIDTH-1:0] r_fifo_data [RSP_DEPTH];
  logic [ADDR_WIDTH-1:0] r_fifo_addr [RSP_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;

  logic [CNT_W-1:0]      w_used;
  logic                  w_req_ready;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_rsp_valid;

  function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RSP_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // A slot counts as used from acceptance until its response is popped.
  assign w_used      = CNT_W'(r_rd_enb) + CNT_W'(r_rd_pend) + r_count;
  assign w_req_ready = !rst && (w_used < CNT_W'(RSP_DEPTH));
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_rsp_valid = (r_count != '0);
  assign w_push      = r_rd_pend;
  assign w_pop       = w_rsp_valid && bus.rsp_ready;

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  // Head outputs read as zero while the FIFO is empty.
  assign bus.rsp_data  = w_rsp_valid ? r_fifo_data[r_rptr] : '0;
  assign bus.rsp_addr  = w_rsp_valid ? r_fifo_addr[r_rptr] : '0;

  assign bus.wr_enb  = r_wr_enb;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign bus.rd_enb  = r_rd_enb;
  assign bus.rd_addr = r_rd_addr;

  // Issue stage: turn an accepted command into one RAM write or read strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_enb  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_enb  <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_wr_enb <= w_accept && bus.req_wr;
      r_rd_enb <= w_accept && !bus.req_wr;
      if (w_accept && bus.req_wr) begin
        r_wr_addr <= bus.req_addr;
        r_wr_data <= bus.req_wdata;
      end
      if (w_accept && !bus.req_wr) begin
        r_rd_addr <= bus.req_addr;
      end
    end
  end

  // RAM stage: remember which read the RAM answers on rd_data next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend   <= 1'b0;
      r_pend_addr <= '0;
    end else begin
      r_rd_pend   <= r_rd_enb;
      r_pend_addr <= r_rd_addr;
    end
  end

  // FIFO storage: capture read data with its address. No reset is needed
  // because only entries below the count are ever visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= bus.rd_data;
      r_fifo_addr[r_wptr] <= r_pend_addr;
    end
  end

  // FIFO pointers and occupancy. A push and a pop on the same edge leave the
  // count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= f_next_ptr(r_wptr);
      if (w_pop)  r_rptr <= f_next_ptr(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Bench for ram_req_ctrl: models the RAM, drives requests and response
// backpressure, and checks responses against a reference memory and an
// in-order queue of expected read results.
module tb_ram_req_ctrl;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b0;

  ram_req_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // RAM model: writes land on the edge, reads return one cycle later.
  logic [DW-1:0] ram_mem [16];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= 8'(i) ^ 8'h5A;
    end else if (bus.wr_enb) begin
      ram_mem[bus.wr_addr] <= bus.wr_data;
    end
    if (bus.rd_enb) bus.rd_data <= ram_mem[bus.rd_addr];
  end

  // Reference model: memory contents as of command order, expected responses.
  logic [DW-1:0]    ref_mem [16];
  logic [AW+DW-1:0] exp_q [$];
  logic [AW+DW-1:0] exp_head;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic          o_ready, o_rvalid, o_wr, o_rd;
  logic [AW-1:0] o_raddr, o_wa, o_ra;
  logic [DW-1:0] o_rdata, o_wd;
  logic          acc, pop;

  // One cycle: sample outputs mid-cycle, then drive inputs for the next edge.
  task automatic tick(input logic v, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic rr);
    @(negedge clk);
    cyc++;
    o_ready  = bus.req_ready;
    o_rvalid = bus.rsp_valid;
    o_rdata  = bus.rsp_data;
    o_raddr  = bus.rsp_addr;
    o_wr     = bus.wr_enb;
    o_wa     = bus.wr_addr;
    o_wd     = bus.wr_data;
    o_rd     = bus.rd_enb;
    o_ra     = bus.rd_addr;
    bus.req_valid = v;
    bus.req_wr    = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.rsp_ready = rr;
    acc = v && o_ready;
    pop = o_rvalid && rr;
    if (acc) begin
      if (w) ref_mem[a] = d;
      else   exp_q.push_back({a, ref_mem[a]});
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0, 4'(k), 8'h00, 1'b0);
      n_cmp++;
      if ({o_ready, o_rvalid, o_wr, o_rd} !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_flags: got ready/rvalid/wr/rd=%b expected 0000",
                 {o_ready, o_rvalid, o_wr, o_rd});
      end
      n_cmp++;
      if ({o_wa, o_wd, o_ra, o_raddr, o_rdata} !== '0) begin
        n_bad++;
        $display("FAIL reset_buses: got wa=%h wd=%h ra=%h raddr=%h rdata=%h expected 0",
                 o_wa, o_wd, o_ra, o_raddr, o_rdata);
      end
    end
    tick(1'b0, 1'b0, '0, '0, 1'b0);
    rst = 1'b0;
    tick(1'b0, 1'b0, '0, '0, 1'b0);
    n_cmp++;
    if ({o_ready, o_rvalid, o_wr, o_rd} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_release: got ready/rvalid/wr/rd=%b expected 1000",
               {o_ready, o_rvalid, o_wr, o_rd});
    end
  endtask

  task automatic test_write_read();
    tick(1'b1, 1'b1, 4'd3, 8'hA5, 1'b1);
    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_bad++; $display("FAIL wr_accept: ready=%b expected 1", o_ready);
    end
    tick(1'b1, 1'b0, 4'd3, 8'h00, 1'b1);
    n_cmp++;
    if ({o_wr, o_rd, o_wa, o_wd} !== {1'b1, 1'b0, 4'd3, 8'hA5}) begin
      n_bad++;
      $display("FAIL wr_issue: got wr=%b rd=%b addr=%h data=%h expected wr=1 rd=0 addr=3 data=a5",
               o_wr, o_rd, o_wa, o_wd);
    end
    tick(1'b0, 1'b0, '0, '0, 1'b1);
    n_cmp++;
    if ({o_wr, o_rd, o_ra, o_rvalid} !== {1'b0, 1'b1, 4'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL rd_issue: got wr=%b rd=%b addr=%h rvalid=%b expected wr=0 rd=1 addr=3 rvalid=0",
               o_wr, o_rd, o_ra, o_rvalid);
    end
    tick(1'b0, 1'b0, '0, '0, 1'b1);
    n_cmp++;
    if (o_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL rd_early: rvalid=%b expected 0 two cycles after accept", o_rvalid);
    end
    tick(1'b0, 1'b0, '0, '0, 1'b1);
    n_cmp++;
    if ({o_rvalid, o_raddr, o_rdata} !== {1'b1, 4'd3, 8'hA5}) begin
      n_bad++;
      $display("FAIL rd_response: got rvalid=%b addr=%h data=%h expected 1 3 a5",
               o_rvalid, o_raddr, o_rdata);
    end
    if (pop && exp_q.size() > 0) exp_head = exp_q.pop_front();
    tick(1'b0, 1'b0, '0, '0, 1'b1);
    n_cmp++;
    if (o_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL rd_single: rvalid=%b expected 0 after pop", o_rvalid);
    end
  endtask

  task automatic test_streaming();
    int i = 0, npop = 0, c0 = 0, last = 0;
    for (int t = 0; t < 60 && npop < 16; t++) begin
      tick(i < 16, 1'b0, 4'(i), 8'h00, 1'b1);
      if (i < 16) begin
        n_cmp++;
        if (o_ready !== 1'b1) begin
          n_bad++; $display("FAIL stream_ready: ready=%b expected 1 at read %0d", o_ready, i);
        end
      end
      if (acc) begin
        if (i == 0) c0 = cyc;
        i++;
      end
      if (pop) begin
        exp_head = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_cmp++;
        if ({o_raddr, o_rdata} !== exp_head) begin
          n_bad++;
          $display("FAIL stream_rsp: got addr=%h data=%h expected %h", o_raddr, o_rdata, exp_head);
        end
        n_cmp++;
        if (cyc !== ((npop == 0) ? c0 + 3 : last + 1)) begin
          n_bad++;
          $display("FAIL stream_timing: response %0d at cycle %0d expected %0d",
                   npop, cyc, (npop == 0) ? c0 + 3 : last + 1);
        end
        last = cyc;
        npop++;
      end
    end
    n_cmp++;
    if (npop !== 16) begin
      n_bad++; $display("FAIL stream_count: got %0d responses expected 16", npop);
    end
  endtask

  task automatic test_backpressure();
    int i = 0, npop = 0;
    logic have_head = 1'b0;
    logic [AW+DW-1:0] head = '0;
    for (int t = 0; t < 12; t++) begin
      tick(i < 6, 1'b0, 4'(8 + i), 8'h00, 1'b0);
      if (acc) i++;
      if (o_rvalid) begin
        if (have_head) begin
          n_cmp++;
          if ({o_raddr, o_rdata} !== head) begin
            n_bad++;
            $display("FAIL bp_stable: head %h changed to %h", head, {o_raddr, o_rdata});
          end
        end
        head = {o_raddr, o_rdata};
        have_head = 1'b1;
      end
    end
    n_cmp++;
    if (i !== DEPTH) begin
      n_bad++; $display("FAIL bp_accepted: got %0d accepted expected %0d", i, DEPTH);
    end
    n_cmp++;
    if ({o_ready, o_rvalid} !== 2'b01) begin
      n_bad++; $display("FAIL bp_stall: ready/rvalid=%b expected 01", {o_ready, o_rvalid});
    end
    for (int t = 0; t < 40 && npop < 6; t++) begin
      tick(i < 6, 1'b0, 4'(8 + i), 8'h00, 1'b1);
      if (acc) i++;
      if (pop) begin
        exp_head = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_cmp++;
        if ({o_raddr, o_rdata} !== exp_head) begin
          n_bad++;
          $display("FAIL bp_rsp: got addr=%h data=%h expected %h", o_raddr, o_rdata, exp_head);
        end
        npop++;
      end
    end
    n_cmp++;
    if (npop !== 6) begin
      n_bad++; $display("FAIL bp_count: got %0d responses expected 6", npop);
    end
  endtask

  task automatic test_mixed();
    int nacc = 0;
    for (int t = 0; t < 4000 && nacc < 200; t++) begin
      tick($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), 8'($urandom),
           $urandom_range(0, 3) != 0);
      if (acc) nacc++;
      if (o_wr && o_rd) begin
        n_cmp++; n_bad++;
        $display("FAIL mix_enables: wr_enb and rd_enb both high at cycle %0d", cyc);
      end
      if (pop) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL mix_rsp: unexpected response addr=%h data=%h", o_raddr, o_rdata);
        end else begin
          exp_head = exp_q.pop_front();
          if ({o_raddr, o_rdata} !== exp_head) begin
            n_bad++;
            $display("FAIL mix_rsp: got addr=%h data=%h expected %h", o_raddr, o_rdata, exp_head);
          end
        end
      end
    end
    for (int t = 0; t < 20; t++) begin
      tick(1'b0, 1'b0, '0, '0, 1'b1);
      if (pop) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL mix_drain: unexpected response addr=%h data=%h", o_raddr, o_rdata);
        end else begin
          exp_head = exp_q.pop_front();
          if ({o_raddr, o_rdata} !== exp_head) begin
            n_bad++;
            $display("FAIL mix_drain: got addr=%h data=%h expected %h", o_raddr, o_rdata, exp_head);
          end
        end
      end
    end
    n_cmp++;
    if (nacc !== 200 || exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL mix_done: accepted %0d expected 200, %0d responses missing expected 0",
               nacc, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int i = 0, got = 0;
    for (int t = 0; t < 10 && i < 4; t++) begin
      tick(1'b1, 1'b0, 4'(i), 8'h00, 1'b0);
      if (acc) i++;
    end
    tick(1'b0, 1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    tick(1'b0, 1'b0, '0, '0, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    n_cmp++;
    if ({o_ready, o_rvalid, o_rd} !== 3'b000) begin
      n_bad++;
      $display("FAIL midrst_clear: ready/rvalid/rd=%b expected 000", {o_ready, o_rvalid, o_rd});
    end
    for (int t = 0; t < 6; t++) begin
      tick(1'b0, 1'b0, '0, '0, 1'b1);
      n_cmp++;
      if (o_rvalid !== 1'b0) begin
        n_bad++; $display("FAIL midrst_stale: rvalid=%b expected 0 after reset", o_rvalid);
      end
    end
    tick(1'b1, 1'b0, 4'd5, 8'h00, 1'b1);
    n_cmp++;
    if (acc !== 1'b1) begin
      n_bad++; $display("FAIL midrst_accept: ready=%b expected 1", o_ready);
    end
    for (int t = 0; t < 8 && got == 0; t++) begin
      tick(1'b0, 1'b0, '0, '0, 1'b1);
      if (pop) begin
        got = 1;
        exp_head = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_cmp++;
        if ({o_raddr, o_rdata} !== exp_head) begin
          n_bad++;
          $display("FAIL midrst_read: got addr=%h data=%h expected %h", o_raddr, o_rdata, exp_head);
        end
      end
    end
    n_cmp++;
    if (got !== 1) begin
      n_bad++; $display("FAIL midrst_timeout: got %0d responses expected 1", got);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    test_reset();
    test_streaming();
    test_write_read();
    test_backpressure();
    test_mixed();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
